// File: rtl/fpga_bootrom_ctrl_if.sv
// Request/grant/rvalid bus between a core fetch port and the boot ROM.
// The master drives request, write enable and address; the ROM slave answers.
interface fpga_bootrom_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/fpga_bootrom_ctrl.sv
// Strap-selected FPGA boot ROM: lui/addi/jalr jump to the boot target, then jal x0,0 traps.
// Optional FPGA_BOOTROM_DBG_HOLD_EN adds dbg_hold_i, which traps the core on w0..w2.
module fpga_bootrom_ctrl #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NUM_WORDS   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h1A000000,
    parameter logic [31:0] BOOT_ADDR_0 = 32'h1C008080,
    parameter logic [31:0] BOOT_ADDR_1 = 32'h1C000080,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 boot_sel_i,
`ifdef FPGA_BOOTROM_DBG_HOLD_EN
    input  logic                 dbg_hold_i,
`endif
    fpga_bootrom_ctrl_if.slave   bus,
    output logic                 boot_done_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE      = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] ROM_BYTES = ADDR_WIDTH'(4 * NUM_WORDS);
    localparam logic [31:0]           TRAP_WORD = 32'h0000006F;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GOT0 = 2'd1;
    localparam logic [1:0] S_GOT1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic                  r_sel_q;
    logic [1:0]            r_state;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic                  r_boot_done;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [31:0]           w_ba;
    logic [31:0]           w_word0;
    logic [31:0]           w_word1;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_gnt;
    logic                  w_rd_ok;
    logic                  w_hold;
    logic                  w_advance;
    logic [31:0]           w_rom_word;
    logic [1:0]            w_state_nxt;

    // Image is rebuilt from the latched strap, so no memory array exists to reset.
    assign w_ba    = r_sel_q ? BOOT_ADDR_1 : BOOT_ADDR_0;
    assign w_word0 = ((w_ba + 32'h00000800) & 32'hFFFFF000) | 32'h00000537;
    assign w_word1 = {w_ba[11:0], 20'h50513};

    assign w_offset = bus.addr_i - BASE;
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_err    = bus.we_i | (bus.addr_i[1:0] != 2'b00) |
                      (bus.addr_i < BASE) | (w_offset >= ROM_BYTES);
    assign w_gnt    = bus.req_i & ~RST;
    assign w_rd_ok  = w_gnt & ~w_err;

`ifdef FPGA_BOOTROM_DBG_HOLD_EN
    assign w_hold = dbg_hold_i & (w_idx < IDX_W'(3));
`else
    assign w_hold = 1'b0;
`endif
    assign w_advance = w_rd_ok & ~w_hold;

    always_comb begin
        w_rom_word = TRAP_WORD;
        if (!w_hold) begin
            case (w_idx)
                IDX_W'(0): w_rom_word = w_word0;
                IDX_W'(1): w_rom_word = w_word1;
                IDX_W'(2): w_rom_word = 32'h00050067;
                default:   w_rom_word = TRAP_WORD;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = (w_idx == IDX_W'(0)) ? S_GOT0 : S_IDLE;
            S_GOT0: w_state_nxt = (w_idx == IDX_W'(1)) ? S_GOT1 :
                                  (w_idx == IDX_W'(0)) ? S_GOT0 : S_IDLE;
            S_GOT1: w_state_nxt = (w_idx == IDX_W'(2)) ? S_DONE :
                                  (w_idx == IDX_W'(0)) ? S_GOT0 : S_IDLE;
            default: w_state_nxt = S_DONE;
        endcase
    end

    // The strap keeps following the pin throughout reset and freezes on release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel_q <= boot_sel_i;
        end
    end

    // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_boot_done <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_err   <= w_err;
                r_rdata <= w_err ? 32'h0 : w_rom_word;
            end
            if (w_rd_ok && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_advance) begin
                r_state     <= w_state_nxt;
                r_boot_done <= (w_state_nxt == S_DONE);
            end
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;
    assign bus.err_o    = r_err;
    assign boot_done_o  = r_boot_done;
    assign fetch_cnt_o  = r_cnt;
endmodule
